// File: rtl/apb3_csr_pkg.sv
// Shared definitions for the APB3 CSR bank: transfer phases, saturation limit
// and the word-offset layout of the register map.
package apb3_csr_pkg;

    localparam logic [1:0] PH_IDLE  = 2'd0;
    localparam logic [1:0] PH_VALID = 2'd1;
    localparam logic [1:0] PH_RESP  = 2'd2;

    localparam logic [31:0] SAT_MAX = 32'hFFFF_FFFF;

    // k selects a word inside each block; single-word blocks are addressed with k = 0
    function automatic int rw_idx(input int num_rw, input int k);
        return (k < num_rw) ? k : -1;
    endfunction

    function automatic int irq_st_idx(input int num_rw, input int k);
        return num_rw + k;
    endfunction

    function automatic int irq_en_idx(input int num_rw, input int k);
        return num_rw + 1 + k;
    endfunction

    function automatic int cnt_idx(input int num_rw, input int k);
        return num_rw + 2 + k;
    endfunction

endpackage

// File: rtl/apb3_csr_counter.sv
// 32-bit saturating event counter; a clear coinciding with an increment leaves 1.
module apb3_csr_counter
    import apb3_csr_pkg::*;
(
    input  logic        s_apb3_clk,
    input  logic        s_apb3_rstn,
    input  logic        i_clr,
    input  logic        i_inc,
    output logic [31:0] o_cnt
);

    logic [31:0] r_cnt;

    // Count register: clear has priority, increment stops at the saturation limit
    always_ff @(posedge s_apb3_clk or negedge s_apb3_rstn) begin
        if (!s_apb3_rstn) begin
            r_cnt <= 32'h0000_0000;
        end else if (i_clr) begin
            r_cnt <= i_inc ? 32'h0000_0001 : 32'h0000_0000;
        end else if (i_inc && (r_cnt != SAT_MAX)) begin
            r_cnt <= r_cnt + 32'h0000_0001;
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/apb3_csr_bank.sv
// Parametrised APB3 register bank: RW control words, sticky IRQ status/enable
// and saturating event counters behind a one-wait-state APB3 front end.
module apb3_csr_bank
    import apb3_csr_pkg::*;
#(
    parameter int                   ADDR_WTH = 10,
    parameter int                   BASE_IDX = 32'h0000_0080,
    parameter int                   NUM_RW   = 13,
    parameter logic [NUM_RW*32-1:0] RW_RST   = '0,
    parameter int                   NUM_IRQ  = 8,
    parameter int                   NUM_CNT  = 4
)(
    input  logic                                  s_apb3_clk,
    input  logic                                  s_apb3_rstn,
    input  logic [ADDR_WTH-1:0]                   s_apb3_paddr,
    input  logic                                  s_apb3_psel,
    input  logic                                  s_apb3_penable,
    input  logic                                  s_apb3_pwrite,
    input  logic [31:0]                           s_apb3_pwdata,
    output logic [31:0]                           s_apb3_prdata,
    output logic                                  s_apb3_pready,
    output logic                                  s_apb3_pslverror,
    output logic [NUM_RW*32-1:0]                  rw_regs,
    input  logic [NUM_IRQ-1:0]                    irq_evt,
    input  logic [((NUM_CNT > 0) ? NUM_CNT : 1)-1:0] cnt_inc,
    output logic                                  irq
);

    localparam int CNT_W     = (NUM_CNT > 0) ? NUM_CNT : 1;
    localparam int RW_SEL_W  = (NUM_RW > 1) ? $clog2(NUM_RW) : 1;
    localparam int CNT_SEL_W = (NUM_CNT > 1) ? $clog2(NUM_CNT) : 1;

    logic [1:0]          r_state;
    logic [1:0]          w_state_nxt;
    logic                w_capture;
    logic                w_commit;
    logic [ADDR_WTH-3:0] r_idx;
    logic                r_write;
    logic [31:0]         r_wdata;
    logic [31:0]         r_prdata;
    logic                r_pready;
    logic                r_pslverr;
    logic [31:0]         r_rw [NUM_RW];
    logic [NUM_IRQ-1:0]  r_irq_st;
    logic [NUM_IRQ-1:0]  r_irq_en;
    logic                r_irq;
    logic [NUM_IRQ-1:0]  w_w1c;
    logic [31:0]         w_cnt [CNT_W];
    logic [CNT_W-1:0]    w_cnt_clr;
    int                  w_off;
    int                  w_cnt_off;
    logic                w_hit_rw, w_hit_st, w_hit_en, w_hit_cnt, w_err;
    logic [RW_SEL_W-1:0] w_rw_sel;
    logic [CNT_SEL_W-1:0] w_cnt_sel;
    logic [31:0]         w_rdata;
    logic                w_unused;

    // Byte-lane bits never affect a word-wide register bank
    assign w_unused = &{1'b0, s_apb3_paddr[1:0]};

    // Phase register
    always_ff @(posedge s_apb3_clk or negedge s_apb3_rstn) begin
        if (!s_apb3_rstn) begin
            r_state <= PH_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Phase sequencing: once a setup is seen the transfer runs to completion
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            PH_IDLE: begin
                if (s_apb3_psel && !s_apb3_penable) w_state_nxt = PH_VALID;
                else                                w_state_nxt = PH_IDLE;
            end
            PH_VALID: w_state_nxt = PH_RESP;
            PH_RESP:  w_state_nxt = PH_IDLE;
            default:  w_state_nxt = PH_IDLE;
        endcase
    end

    // Phase-derived strobes
    always_comb begin
        w_capture = 1'b0;
        w_commit  = 1'b0;
        case (r_state)
            PH_IDLE:  w_capture = s_apb3_psel & ~s_apb3_penable;
            PH_VALID: w_commit  = 1'b1;
            default: begin
                w_capture = 1'b0;
                w_commit  = 1'b0;
            end
        endcase
    end

    // Setup capture of index, direction and data
    always_ff @(posedge s_apb3_clk or negedge s_apb3_rstn) begin
        if (!s_apb3_rstn) begin
            r_idx   <= '0;
            r_write <= 1'b0;
            r_wdata <= 32'h0000_0000;
        end else if (w_capture) begin
            r_idx   <= s_apb3_paddr[ADDR_WTH-1:2];
            r_write <= s_apb3_pwrite;
            r_wdata <= s_apb3_pwdata;
        end
    end

    // Address decode relative to BASE_IDX
    always_comb begin
        w_off     = int'(r_idx) - BASE_IDX;
        w_cnt_off = w_off - cnt_idx(NUM_RW, 0);
        w_hit_rw  = 1'b0;
        w_hit_st  = 1'b0;
        w_hit_en  = 1'b0;
        w_hit_cnt = 1'b0;
        w_err     = 1'b0;
        if ((w_off >= rw_idx(NUM_RW, 0)) && (w_off < irq_st_idx(NUM_RW, 0))) w_hit_rw = 1'b1;
        else if (w_off == irq_st_idx(NUM_RW, 0))                               w_hit_st = 1'b1;
        else if (w_off == irq_en_idx(NUM_RW, 0))                               w_hit_en = 1'b1;
        else if ((w_off >= cnt_idx(NUM_RW, 0)) && (w_off < cnt_idx(NUM_RW, NUM_CNT))) w_hit_cnt = 1'b1;
        else                                                                   w_err = 1'b1;
        w_rw_sel  = w_off[RW_SEL_W-1:0];
        w_cnt_sel = w_cnt_off[CNT_SEL_W-1:0];
    end

    // Read mux; unused IRQ bits and unmapped words read as zero
    always_comb begin
        w_rdata = 32'h0000_0000;
        if (w_hit_rw)       w_rdata = r_rw[w_rw_sel];
        else if (w_hit_st)  w_rdata[NUM_IRQ-1:0] = r_irq_st;
        else if (w_hit_en)  w_rdata[NUM_IRQ-1:0] = r_irq_en;
        else if (w_hit_cnt) w_rdata = w_cnt[w_cnt_sel];
        else                w_rdata = 32'h0000_0000;
    end

    // Response registers: data sampled at the end of the valid cycle
    always_ff @(posedge s_apb3_clk or negedge s_apb3_rstn) begin
        if (!s_apb3_rstn) begin
            r_prdata  <= 32'h0000_0000;
            r_pready  <= 1'b0;
            r_pslverr <= 1'b0;
        end else begin
            r_pready <= w_commit;
            if (w_commit) begin
                r_prdata  <= w_rdata;
                r_pslverr <= w_err;
            end
        end
    end

    // RW register array
    always_ff @(posedge s_apb3_clk or negedge s_apb3_rstn) begin
        if (!s_apb3_rstn) begin
            for (int i = 0; i < NUM_RW; i++) r_rw[i] <= RW_RST[32*i +: 32];
        end else if (w_commit && r_write && w_hit_rw) begin
            r_rw[w_rw_sel] <= r_wdata;
        end
    end

    for (genvar g = 0; g < NUM_RW; g++) begin : g_rw_out
        assign rw_regs[32*g +: 32] = r_rw[g];
    end

    assign w_w1c = (w_commit && r_write && w_hit_st) ? r_wdata[NUM_IRQ-1:0] : '0;

    // Sticky status (set beats clear), enable mask and registered interrupt line
    always_ff @(posedge s_apb3_clk or negedge s_apb3_rstn) begin
        if (!s_apb3_rstn) begin
            r_irq_st <= '0;
            r_irq_en <= '0;
            r_irq    <= 1'b0;
        end else begin
            r_irq_st <= (r_irq_st & ~w_w1c) | irq_evt;
            r_irq    <= |(r_irq_st & r_irq_en);
            if (w_commit && r_write && w_hit_en) r_irq_en <= r_wdata[NUM_IRQ-1:0];
        end
    end

    // One-hot clear strobe for the addressed counter
    always_comb begin
        w_cnt_clr = '0;
        if (w_commit && r_write && w_hit_cnt) w_cnt_clr[w_cnt_sel] = 1'b1;
        else                                  w_cnt_clr = '0;
    end

    for (genvar k = 0; k < NUM_CNT; k++) begin : g_cnt
        apb3_csr_counter u_cnt (
            .s_apb3_clk  (s_apb3_clk),
            .s_apb3_rstn (s_apb3_rstn),
            .i_clr       (w_cnt_clr[k]),
            .i_inc       (cnt_inc[k]),
            .o_cnt       (w_cnt[k])
        );
    end

    if (NUM_CNT == 0) begin : g_no_cnt
        assign w_cnt[0] = 32'h0000_0000;
    end

    assign s_apb3_prdata    = r_prdata;
    assign s_apb3_pready    = r_pready;
    assign s_apb3_pslverror = r_pslverr;
    assign irq              = r_irq;

endmodule
